// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
//
// Iterative shift-add sequencer for the RV32M multiply group
// (MUL / MULH / MULHSU / MULHU). It sits beside the ALU in EX and replaces the
// combinational multiplier array. Each CALC cycle retires BITS_PER_CYCLE bits
// of the multiplier.
//
// The multiply runs on operand magnitudes into an unsigned 64-bit
// accumulator. A single conditional two's-complement negate of the full
// product restores the sign.
//
// Parameters
//   BITS_PER_CYCLE  multiplier bits retired per CALC cycle. Legal values are
//                   1, 2, 4 and 8, so that the value divides 32.
//                   N = 32 / BITS_PER_CYCLE is the CALC length.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands/op valid
//   in_ready   out  1   block can accept (IDLE only)
//   A          in   32  rs1 operand
//   B          in   32  rs2 operand
//   ALUCtrl    in   5   multiply op select. Unknown codes behave as MUL.
//   flush      in   1   synchronous abort; returns to IDLE next edge
//   out_valid  out  1   result valid (DONE only)
//   out_ready  in   1   consumer takes result
//   result     out  32  selected product half, held until the next result
//   busy       out  1   state != IDLE; stalls PC / regfile write
//
// Configuration macro
//   MUL_EARLY_EXIT_EN  When defined, CALC finishes in the cycle after which
//                      the remaining multiplier bits are all zero.
//                      When undefined, CALC always takes N cycles, so the
//                      timing is constant and does not depend on operands.
// -----------------------------------------------------------------------------
module mul_seq_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALUCtrl,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  // Op encodings shared with the ALU decode (defines.vh values).
  localparam logic [4:0] ALU_MUL   = 5'b01010;
  localparam logic [4:0] ALU_MULH  = 5'b01011;
  localparam logic [4:0] ALU_MULSU = 5'b01100;
  localparam logic [4:0] ALU_MULU  = 5'b01101;

  localparam int N     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Magnitude of a possibly signed operand. 0x80000000 maps to itself, and
  // that value is read back as the unsigned 2^31, which is the intent.
  function automatic logic [31:0] f_mag(input logic [31:0] v,
                                        input logic        is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] f_cond_neg(input logic [63:0] v,
                                             input logic        neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // High half for MULH/MULHSU/MULHU. Low half for MUL and any other code.
  function automatic logic [31:0] f_select(input logic [63:0] p,
                                           input logic [4:0]  op);
    logic [31:0] sel;
    if (op == ALU_MULH || op == ALU_MULSU || op == ALU_MULU)
      sel = p[63:32];
    else
      sel = p[31:0];
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;

  logic [63:0]        r_mcand;    // |A|, shifted left BITS_PER_CYCLE per step
  logic [31:0]        r_mplier;   // |B|, shifted right BITS_PER_CYCLE per step
  logic [63:0]        r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_neg;
  logic [4:0]         r_op;
  logic [31:0]        r_result;

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic               w_finish;
  logic [63:0]        w_partial;
  logic [63:0]        w_acc_nxt;

  // ---------------------------------------------------------------------------
  // Operand decode (at accept)
  // ---------------------------------------------------------------------------
  // Unknown codes are treated like MUL, which uses signed x signed operands.
  // The low half of the product is the same for every signedness anyway.
  assign w_a_signed = (ALUCtrl != ALU_MULU);
  assign w_b_signed = (ALUCtrl != ALU_MULU) && (ALUCtrl != ALU_MULSU);

  // ---------------------------------------------------------------------------
  // Shift-add step
  // ---------------------------------------------------------------------------
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (r_mplier[j])
        w_partial = w_partial + (r_mcand << j);
    end
  end

  assign w_acc_nxt = r_acc + w_partial;

`ifdef MUL_EARLY_EXIT_EN
  logic [31:0] w_mplier_rem;
  assign w_mplier_rem = r_mplier >> BITS_PER_CYCLE;
  // Stop once no set multiplier bits remain beyond this step. The counter
  // still bounds the op at N cycles.
  assign w_last = (r_count == '0) || (w_mplier_rem == 32'd0);
`else
  assign w_last = (r_count == '0);
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  // flush has priority over in_valid and over out_ready in every state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // No new accept here. in_ready only goes high once IDLE is reached.
        if (flush || out_ready)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_op     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mcand  <= {32'd0, f_mag(A, w_a_signed)};
      r_mplier <= f_mag(B, w_b_signed);
      r_neg    <= (A[31] & w_a_signed) ^ (B[31] & w_b_signed);
      r_op     <= ALUCtrl;
      r_acc    <= '0;
      r_count  <= CNT_W'(N - 1);
    end else if (w_step) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
      r_count  <= r_count - CNT_W'(1);
      // The final add, the sign fix and the half select all happen in the
      // same cycle. result therefore changes only here and on reset. A flush
      // leaves it unchanged.
      if (w_finish)
        r_result <= f_select(f_cond_neg(w_acc_nxt, r_neg), r_op);
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;
  localparam int BPC = 1;
  localparam int N   = 32 / BPC;

  localparam logic [4:0] OP_MUL   = 5'b01010;
  localparam logic [4:0] OP_MULH  = 5'b01011;
  localparam logic [4:0] OP_MULSU = 5'b01100;
  localparam logic [4:0] OP_MULU  = 5'b01101;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic        in_ready, out_valid, busy;
  logic [31:0] A, B, result;
  logic [4:0]  ALUCtrl;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUCtrl(ALUCtrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: mathematical product of the sign/zero-extended operands.
  function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output int lat);
    logic as, bs;
    logic [63:0] ea, eb, p;
    as = (op != OP_MULU);
    bs = (op != OP_MULU) && (op != OP_MULSU);
    ea = as ? {{32{a[31]}}, a} : {32'd0, a};
    eb = bs ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    res = (op == OP_MULH || op == OP_MULSU || op == OP_MULU) ? p[63:32] : p[31:0];
`ifdef MUL_EARLY_EXIT_EN
    begin
      logic [31:0] bm;
      int msb;
      bm  = (bs && b[31]) ? -b : b;
      msb = -1;
      for (int i = 0; i < 32; i++) if (bm[i]) msb = i;
      lat = (msb < 0) ? 1 : (msb + BPC) / BPC;
    end
`else
    lat = N;
`endif
  endfunction

  // Called #1 after a posedge, with the DUT in IDLE.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUCtrl = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUCtrl = 5'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag, output logic [31:0] got);
    logic [31:0] er;
    int el, cyc;
    model(op, a, b, er, el);
    chk({tag, ":idle_rdy"}, {in_ready, busy}, 2'b10);
    start_op(op, a, b);
    chk({tag, ":calc_busy"}, {in_ready, busy}, 2'b01);
    wait_valid(cyc);
    chk({tag, ":latency"}, 64'(cyc), 64'(el));
    chk({tag, ":result"}, result, er);
    got = result;
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, ":hold"}, {out_valid, in_ready, busy, result}, {1'b1, 1'b0, 1'b1, er});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":to_idle"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] got, er;
    int cyc, el, seen;
    logic [4:0] ops[5];
    ops[0] = OP_MUL; ops[1] = OP_MULH; ops[2] = OP_MULSU; ops[3] = OP_MULU; ops[4] = 5'd3;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUCtrl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {in_ready, out_valid, busy, result}, {3'b100, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(OP_MUL, 32'd7, 32'd6, 0, "mul7x6", got);
    chk("mul7x6_const", got, 32'h2A);
    do_op(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulh_m1", got);
    chk("mulh_m1_const", got, 32'h0);
    do_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulu_max", got);
    chk("mulu_max_const", got, 32'hFFFFFFFE);
    do_op(OP_MULSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulsu_m1", got);
    chk("mulsu_m1_const", got, 32'hFFFFFFFF);
    do_op(OP_MUL, 32'h80000000, 32'h80000000, 0, "mul_min", got);
    chk("mul_min_const", got, 32'h0);
    do_op(OP_MULH, 32'h80000000, 32'h80000000, 0, "mulh_min", got);
    chk("mulh_min_const", got, 32'h40000000);

    // Backpressure: the result is held for 10 cycles.
    do_op(OP_MUL, 32'h1234, 32'h10, 10, "bp", got);
    chk("bp_const", got, 32'h12340);

    // flush during CALC aborts the op.
    start_op(OP_MUL, 32'h1234, 32'h7FFFFFFF);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc_idle", {out_valid, in_ready, busy}, 3'b010);
    seen = 0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    do_op(OP_MUL, 32'd3, 32'd5, 0, "after_flush", got);
    chk("after_flush_const", got, 32'hF);

    // flush in DONE wins over out_ready. result is retained.
    model(OP_MULU, 32'hDEADBEEF, 32'h00C0FFEE, er, el);
    start_op(OP_MULU, 32'hDEADBEEF, 32'h00C0FFEE);
    wait_valid(cyc);
    chk("flush_done_valid", out_valid, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_idle", {out_valid, in_ready, busy, result}, {3'b010, er});

    // flush wins over in_valid in IDLE.
    in_valid = 1'b1; flush = 1'b1; A = 32'd9; B = 32'd9; ALUCtrl = OP_MUL;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", {in_ready, busy}, 2'b10);

    // Async reset during CALC.
    start_op(OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_calc", {in_ready, out_valid, busy, result}, {3'b100, 32'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    chk("reset_no_stale", 64'(seen), 64'd0);

`ifdef MUL_EARLY_EXIT_EN
    do_op(OP_MUL, 32'h12345678, 32'd1, 0, "ee_b1", got);
    chk("ee_b1_const", got, 32'h12345678);
    do_op(OP_MUL, 32'h12345678, 32'd0, 0, "ee_b0", got);
    chk("ee_b0_const", got, 32'h0);
`endif

    for (int t = 0; t < 300; t++) begin
      do_op(ops[$urandom_range(0, 4)], pick(), pick(), $urandom_range(0, 2), "rand", got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
